// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a per-bit don't-care mask,
// run-time overlap mode, registered detection pulse and saturating hit counter.
module seq_detect_param #(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b11011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic [LEN-1:0]   cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FW       = $clog2(LEN + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [LEN-1:0]   hist_reg, hist_next;
  logic [LEN-1:0]   pat_reg, pat_next;
  logic [LEN-1:0]   mask_reg, mask_next;
  logic [FW-1:0]    fill_reg, fill_next;
  logic             ovl_reg, ovl_next;
  logic             det_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;

  logic [LEN-1:0]   win;
  logic [LEN-1:0]   miss;
  logic             fill_ok;
  logic             hit;

  assign win = {hist_reg[LEN-2:0], in_bit};

  // A bit only counts against the match if it is compared and differs.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_cmp
    assign miss[gi] = mask_reg[gi] & (win[gi] ^ pat_reg[gi]);
  end

  // The incoming bit completes a full window once LEN-1 bits are already held.
  assign fill_ok = (fill_reg >= (FILL_MAX - FW'(1)));
  // A bit arriving with cfg_load is discarded, so it can never hit.
  assign hit     = in_valid & ~cfg_load & fill_ok & ~(|miss);

  always_comb begin
    hist_next = hist_reg;
    pat_next  = pat_reg;
    mask_next = mask_reg;
    ovl_next  = ovl_reg;
    fill_next = fill_reg;
    cnt_next  = cnt_reg;
    sat_next  = sat_reg;

    if (cfg_load) begin
      pat_next  = cfg_pattern;
      mask_next = cfg_mask;
      ovl_next  = cfg_overlap;
      hist_next = '0;
      fill_next = '0;
    end else if (in_valid) begin
      hist_next = win;
      if (hit && !ovl_reg) begin
        fill_next = '0;
      end else if (fill_reg != FILL_MAX) begin
        fill_next = fill_reg + FW'(1);
      end
    end

    if (cnt_clr) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (hit && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (cnt_next == CNT_MAX) begin
        sat_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= PATTERN;
      mask_reg <= '1;
      ovl_reg  <= OVERLAP;
      det_reg  <= 1'b0;
      cnt_reg  <= '0;
      sat_reg  <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      pat_reg  <= pat_next;
      mask_reg <= mask_next;
      ovl_reg  <= ovl_next;
      det_reg  <= hit;
      cnt_reg  <= cnt_next;
      sat_reg  <= sat_next;
    end
  end

  assign det       = det_reg;
  assign match_cnt = cnt_reg;
  assign cnt_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: stimulus queues each expected detection, monitors pop and
// compare on every det pulse. Instance a: CNT_W=8, instance b: CNT_W=2.
module tb_seq_detect_param;

  localparam int LEN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst         = 1'b1;
  logic           in_valid    = 1'b0;
  logic           in_bit      = 1'b0;
  logic           cfg_load    = 1'b0;
  logic [LEN-1:0] cfg_pattern = 5'b11011;
  logic [LEN-1:0] cfg_mask    = 5'b11111;
  logic           cfg_overlap = 1'b1;
  logic           cnt_clr     = 1'b0;
  logic           sel         = 1'b0;

  logic v_a, v_b, ld_a, ld_b, clr_a, clr_b;
  assign v_a   = in_valid & ~sel;
  assign v_b   = in_valid & sel;
  assign ld_a  = cfg_load & ~sel;
  assign ld_b  = cfg_load & sel;
  assign clr_a = cnt_clr & ~sel;
  assign clr_b = cnt_clr & sel;

  logic       det_a, sat_a, det_b, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  seq_detect_param #(.LEN(LEN), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(v_a), .in_bit(in_bit), .cfg_load(ld_a),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(clr_a), .det(det_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.LEN(LEN), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(v_b), .in_bit(in_bit), .cfg_load(ld_b),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(clr_b), .det(det_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_a = 0;
  int   exp_b = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // One valid bit; if hit is expected the detection is queued for the monitor.
  task automatic send(input logic b, input logic hit, input logic clr = 1'b0);
    in_valid = 1'b1;
    in_bit   = b;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    in_bit   = 1'($urandom_range(0, 1));
    if (sel) begin
      if (clr) exp_b = 0;
      else if (hit && exp_b < 3) exp_b++;
      if (hit) q_b.push_back('{cyc, exp_b});
    end else begin
      if (clr) exp_a = 0;
      else if (hit && exp_a < 255) exp_a++;
      if (hit) q_a.push_back('{cyc, exp_a});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // bits/hits are listed first-bit-first from position n-1 down to 0.
  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] hits,
                        input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], hits[i]);
      idle(gap);
    end
  endtask

  task automatic cfg(input logic [LEN-1:0] pat, input logic [LEN-1:0] mask,
                     input logic ovl, input logic with_bit);
    cfg_pattern = pat;
    cfg_mask    = mask;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    in_valid    = with_bit;
    in_bit      = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    exp_a = 0;
    exp_b = 0;
    check("rst det", int'(det_a), 0);
    check("rst match_cnt", int'(cnt_a), 0);
    check("rst cnt_sat", int'(sat_a), 0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (det_a) begin
      if (q_a.size() == 0) begin
        check("det_a unexpected cycle", cyc, -1);
      end else begin
        e = q_a.pop_front();
        $display("det a: cyc=%0d match_cnt=%0d", cyc, cnt_a);
        check("det_a cycle", cyc, e.cyc);
        check("det_a match_cnt", int'(cnt_a), e.cnt);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (det_b) begin
      if (q_b.size() == 0) begin
        check("det_b unexpected cycle", cyc, -1);
      end else begin
        e = q_b.pop_front();
        $display("det b: cyc=%0d match_cnt=%0d", cyc, cnt_b);
        check("det_b cycle", cyc, e.cyc);
        check("det_b match_cnt", int'(cnt_b), e.cnt);
      end
    end
  end

  initial begin
    do_reset();

    // Overlap, default pattern: hits on bits 5, 8, 11.
    stream(11, 16'b11011011011, 16'b00001001001, 0);
    idle(2);
    check("t1 match_cnt", int'(cnt_a), 3);

    // Non-overlap: hits on bits 5 and 11; counter keeps running across cfg_load.
    cfg(5'b11011, 5'b11111, 1'b0, 1'b0);
    stream(11, 16'b11011011011, 16'b00001000001, 0);
    idle(2);
    check("t2 match_cnt", int'(cnt_a), 5);

    // Overlap with 3-cycle gaps of random in_bit.
    cfg(5'b11011, 5'b11111, 1'b1, 1'b0);
    stream(11, 16'b11011011011, 16'b00001001001, 3);
    idle(2);
    check("t3 match_cnt", int'(cnt_a), 8);

    // Masked pattern 1xxx1: ones stream hits from bit 5 on.
    cfg(5'b10001, 5'b10001, 1'b1, 1'b0);
    stream(7, 16'b1111111, 16'b0000111, 0);
    // cfg_load with a valid bit: the bit is dropped, 5 fresh bits needed.
    cfg(5'b10001, 5'b10001, 1'b1, 1'b1);
    stream(5, 16'b11111, 16'b00001, 0);
    idle(2);
    check("t4 match_cnt", int'(cnt_a), 12);

    // rst mid-stream discards partial progress.
    do_reset();
    stream(4, 16'b1101, 16'b0, 0);
    do_reset();
    stream(6, 16'b111011, 16'b000001, 0);
    idle(2);
    check("t6 match_cnt", int'(cnt_a), 1);
    check("t6 cnt_sat", int'(sat_a), 0);

    // CNT_W=2 instance, mask=0: hits on bits 5..8, counter saturates at 3.
    sel = 1'b1;
    cfg(5'b00000, 5'b00000, 1'b1, 1'b0);
    stream(8, 16'hA5, 16'b00001111, 0);
    idle(1);
    check("t5 match_cnt sat", int'(cnt_b), 3);
    check("t5 cnt_sat set", int'(sat_b), 1);
    send(1'b1, 1'b1, 1'b1);
    idle(1);
    check("t5 clr match_cnt", int'(cnt_b), 0);
    check("t5 clr cnt_sat", int'(sat_b), 0);
    check("t5 other cnt", int'(cnt_a), 1);
    sel = 1'b0;

    idle(2);
    check("pending det_a", q_a.size(), 0);
    check("pending det_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
